// File: rtl/ex_if.sv
// ex_if: ID/EX operand bundle in, EX/MEM result bundle out, for the execute stage
interface ex_if #(parameter int XLEN = 32, parameter int CTRL_W = 4);
  logic flush, in_valid, alu_src;
  logic [XLEN-1:0] reg_data1, reg_data2, imm, pc, wb_data, mem_data;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [1:0] alu_op, forward_a, forward_b;
  logic [4:0] rd_in, rd_out;
  logic [CTRL_W-1:0] ctrl_in, ctrl_out;
  logic stall, out_valid, zero;
  logic [XLEN-1:0] alu_out, pc_branch, rs2_final;
  modport master (
    output flush, in_valid, alu_src, reg_data1, reg_data2, imm, pc, wb_data, mem_data,
           funct3, funct7, alu_op, forward_a, forward_b, rd_in, ctrl_in,
    input  stall, out_valid, zero, alu_out, pc_branch, rs2_final, rd_out, ctrl_out
  );
  modport slave (
    input  flush, in_valid, alu_src, reg_data1, reg_data2, imm, pc, wb_data, mem_data,
           funct3, funct7, alu_op, forward_a, forward_b, rd_in, ctrl_in,
    output stall, out_valid, zero, alu_out, pc_branch, rs2_final, rd_out, ctrl_out
  );
endinterface

// File: rtl/ex_stage_m.sv
// ex_stage_m: execute stage with forwarding, branch adder and iterative RV32M/RV64M unit
module ex_stage_m #(parameter int XLEN = 32, parameter int CTRL_W = 4) (
  input logic clk,
  input logic reset,
  ex_if.slave ex
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [SW-1:0] count, shamt;
  logic [XLEN-1:0] op_a, rs2f, op_b, alu_res, sra_v, ma, mb, a_mag, b_mag, q_s, r_s, m_res, pcb_l, rs2_l;
  logic [2*XLEN-1:0] acc, acc_n, prod;
  logic [XLEN:0] sum, sh, diff;
  logic [2:0] f3_l;
  logic [4:0] rd_l;
  logic [CTRL_W-1:0] ctrl_l;
  logic is_m, accept, last, sgn_a, sgn_b, sa, sb, bz;
  assign op_a = ex.forward_a == 2'b00 ? ex.reg_data1 : ex.forward_a == 2'b01 ? ex.wb_data :
                ex.forward_a == 2'b10 ? ex.mem_data : '0;
  assign rs2f = ex.forward_b == 2'b00 ? ex.reg_data2 : ex.forward_b == 2'b01 ? ex.wb_data :
                ex.forward_b == 2'b10 ? ex.mem_data : '0;
  assign op_b = ex.alu_src ? ex.imm : rs2f;
  assign shamt = op_b[SW-1:0];
  assign sra_v = $signed(op_a) >>> shamt;
  assign is_m = ex.alu_op == 2'b10 && ex.funct7 == 7'b0000001;
  assign accept = state == IDLE && ex.in_valid && is_m;
  assign last = state == BUSY && count == SW'(XLEN - 1);
  assign ex.stall = accept || (state == BUSY && !last);
  always_comb begin
    alu_res = op_a + op_b;
    if (ex.alu_op == 2'b01) alu_res = op_a - op_b;
    else if (ex.alu_op[1]) case (ex.funct3)
      3'b000: alu_res = (!ex.alu_op[0] && ex.funct7[5]) ? op_a - op_b : op_a + op_b;
      3'b001: alu_res = op_a << shamt;
      3'b010: alu_res = XLEN'($signed(op_a) < $signed(op_b));
      3'b011: alu_res = XLEN'(op_a < op_b);
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = ex.funct7[5] ? sra_v : op_a >> shamt;
      3'b110: alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end
  assign sgn_a = ex.funct3[2] ? !ex.funct3[0] : ex.funct3[1] ^ ex.funct3[0];
  assign sgn_b = ex.funct3[2] ? !ex.funct3[0] : ex.funct3[1:0] == 2'b01;
  assign a_mag = sgn_a && op_a[XLEN-1] ? -op_a : op_a;
  assign b_mag = sgn_b && op_b[XLEN-1] ? -op_b : op_b;
  // acc = {hi, lo}: shift-add multiply or restoring-divide step, one bit per cycle
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma} : '0);
  assign sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff = sh - {1'b0, mb};
  assign acc_n = !f3_l[2] ? {sum, acc[XLEN-1:1]} :
                 diff[XLEN] ? {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign prod = sa ^ sb ? -acc_n : acc_n;
  assign q_s = bz ? '1 : sa ^ sb ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
  assign r_s = sa ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
  assign m_res = f3_l[2] ? (f3_l[1] ? r_s : q_s) : f3_l[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (ex.flush || last) ? IDLE : accept ? BUSY : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      ex.out_valid <= 1'b0;
      ex.alu_out <= '0;
      ex.zero <= 1'b0;
      ex.pc_branch <= '0;
      ex.rs2_final <= '0;
      ex.rd_out <= '0;
      ex.ctrl_out <= '0;
    end else if (state == IDLE) begin
      count <= '0;
      ex.out_valid <= ex.in_valid && !is_m && !ex.flush;
      ex.alu_out <= alu_res;
      ex.zero <= alu_res == '0;
      ex.pc_branch <= ex.pc + ex.imm;
      ex.rs2_final <= rs2f;
      ex.rd_out <= ex.rd_in;
      ex.ctrl_out <= ex.ctrl_in;
      if (accept) begin
        ma <= a_mag;
        mb <= b_mag;
        acc <= {{XLEN{1'b0}}, ex.funct3[2] ? a_mag : b_mag};
        sa <= sgn_a && op_a[XLEN-1];
        sb <= sgn_b && op_b[XLEN-1];
        bz <= op_b == '0;
        f3_l <= ex.funct3;
        rd_l <= ex.rd_in;
        ctrl_l <= ex.ctrl_in;
        pcb_l <= ex.pc + ex.imm;
        rs2_l <= rs2f;
      end
    end else begin
      count <= count + SW'(1);
      acc <= acc_n;
      ex.out_valid <= last && !ex.flush;
      if (last && !ex.flush) begin
        ex.alu_out <= m_res;
        ex.zero <= m_res == '0;
        ex.pc_branch <= pcb_l;
        ex.rs2_final <= rs2_l;
        ex.rd_out <= rd_l;
        ex.ctrl_out <= ctrl_l;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage_m.sv
// tb_ex_stage_m: directed vectors with a scoreboard queue checked by an output monitor
module tb_ex_stage_m;
  localparam int XLEN = 32;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int c;
    logic [31:0] alu, pcb, rs2;
    logic [4:0] rd;
    logic [3:0] ctrl;
  } exp_t;
  exp_t sbq[$];
  ex_if #(.XLEN(XLEN), .CTRL_W(CW)) ex();
  ex_stage_m #(.XLEN(XLEN), .CTRL_W(CW)) dut (.clk(clk), .reset(reset), .ex(ex));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (ex.out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d, alu_out %h)", cyc, ex.alu_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("latency", cyc, e.c);
        chk("alu_out", ex.alu_out, e.alu);
        chk("zero", ex.zero, e.alu == 0);
        chk("pc_branch", ex.pc_branch, e.pcb);
        chk("rs2_final", ex.rs2_final, e.rs2);
        chk("rd_out", ex.rd_out, e.rd);
        chk("ctrl_out", ex.ctrl_out, e.ctrl);
      end
    end
  end
  task automatic set(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ex.in_valid = 1'b1;
    ex.alu_op = aop;
    ex.funct3 = f3;
    ex.funct7 = f7;
    ex.reg_data1 = a;
    ex.reg_data2 = b;
    ex.rd_in = rd;
    ex.ctrl_in = rd[3:0] ^ 4'hA;
    ex.alu_src = 1'b0;
    ex.forward_a = 2'b00;
    ex.forward_b = 2'b00;
    ex.imm = 32'h40;
    ex.pc = 32'h1000 + 32'(rd) * 16;
  endtask
  task automatic base(input logic [31:0] e_alu, input logic [31:0] e_rs2);
    sbq.push_back('{c: cyc + 1, alu: e_alu, pcb: ex.pc + ex.imm, rs2: e_rs2, rd: ex.rd_in, ctrl: ex.ctrl_in});
    @(posedge clk);
    #1;
  endtask
  task automatic mop(input logic [31:0] e_alu);
    int n = 0;
    int n0 = cyc;
    sbq.push_back('{c: cyc + 33, alu: e_alu, pcb: ex.pc + ex.imm, rs2: ex.reg_data2, rd: ex.rd_in, ctrl: ex.ctrl_in});
    @(negedge clk);
    while (ex.stall && n < 100) begin
      n++;
      if (n > 1) begin
        ex.wb_data = $urandom;
        ex.mem_data = $urandom;
        ex.reg_data1 = $urandom;
        ex.reg_data2 = $urandom;
        ex.imm = $urandom;
        ex.pc = $urandom;
      end
      @(negedge clk);
    end
    chk("stall_cycles", n, 32);
    chk("stall_drop_cycle", cyc - n0, 32);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
  initial begin
    int n0;
    ex.flush = 1'b0;
    ex.wb_data = '0;
    ex.mem_data = '0;
    set(2'b00, 3'b000, 7'h00, 32'd5, 32'd7, 5'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ex.out_valid, 0);
    chk("rst_alu_out", ex.alu_out, 0);
    chk("rst_zero", ex.zero, 0);
    chk("rst_pc_branch", ex.pc_branch, 0);
    chk("rst_rs2_final", ex.rs2_final, 0);
    chk("rst_rd_out", ex.rd_out, 0);
    chk("rst_ctrl_out", ex.ctrl_out, 0);
    chk("rst_stall", ex.stall, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ex.in_valid = 1'b0;
    @(posedge clk);
    #1;
    set(2'b00, 3'b000, 7'h00, 32'd5, 32'd7, 5'd1);
    base(32'd12, 32'd7);
    set(2'b01, 3'b000, 7'h00, 32'd3, 32'd3, 5'd2);
    base(32'd0, 32'd3);
    set(2'b11, 3'b101, 7'h20, 32'h80000000, 32'h55, 5'd3);
    ex.alu_src = 1'b1;
    ex.imm = 32'd4;
    base(32'hF8000000, 32'h55);
    set(2'b10, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 5'd4);
    base(32'd1, 32'hFFFFFFFF);
    set(2'b00, 3'b000, 7'h00, 32'h111, 32'h222, 5'd9);
    ex.forward_a = 2'b10;
    ex.forward_b = 2'b01;
    ex.mem_data = 32'h10;
    ex.wb_data = 32'h20;
    base(32'h30, 32'h20);
    set(2'b10, 3'b000, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10);
    mop(32'h00000001);
    set(2'b10, 3'b001, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11);
    mop(32'h00000000);
    set(2'b10, 3'b010, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12);
    mop(32'hFFFFFFFF);
    set(2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13);
    mop(32'hFFFFFFFE);
    set(2'b10, 3'b100, 7'h01, -32'sd7, 32'd2, 5'd14);
    mop(-32'sd3);
    set(2'b10, 3'b110, 7'h01, -32'sd7, 32'd2, 5'd15);
    mop(-32'sd1);
    set(2'b10, 3'b101, 7'h01, 32'h12345678, 32'd0, 5'd16);
    mop(32'hFFFFFFFF);
    set(2'b10, 3'b111, 7'h01, 32'h12345678, 32'd0, 5'd17);
    mop(32'h12345678);
    set(2'b10, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 5'd18);
    mop(32'h80000000);
    set(2'b10, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 5'd19);
    mop(32'h00000000);
    set(2'b10, 3'b000, 7'h01, 32'd6, 32'd7, 5'd5);
    mop(32'd42);
    set(2'b00, 3'b000, 7'h00, 32'd100, 32'd23, 5'd6);
    base(32'd123, 32'd23);
    set(2'b10, 3'b000, 7'h01, 32'd9, 32'd9, 5'd7);
    repeat (11) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_before_flush", ex.stall, 1);
    ex.flush = 1'b1;
    @(posedge clk);
    #1;
    ex.flush = 1'b0;
    ex.in_valid = 1'b0;
    @(negedge clk);
    chk("stall_after_flush", ex.stall, 0);
    chk("out_valid_after_flush", ex.out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    set(2'b00, 3'b000, 7'h00, 32'd2, 32'd3, 5'd8);
    base(32'd5, 32'd3);
    set(2'b10, 3'b000, 7'h01, 32'd9, 32'd9, 5'd20);
    n0 = cyc;
    repeat (21) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_before_reset", ex.stall, 1);
    chk("reset_cycle", cyc - n0, 21);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ex.in_valid = 1'b0;
    @(negedge clk);
    chk("stall_after_reset", ex.stall, 0);
    chk("out_valid_after_reset", ex.out_valid, 0);
    chk("alu_out_after_reset", ex.alu_out, 0);
    repeat (40) @(posedge clk);
    #1;
    set(2'b00, 3'b000, 7'h00, 32'h7FFFFFFF, 32'd1, 5'd21);
    base(32'h80000000, 32'd1);
    ex.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
